// File: rtl/loop_sequencer_if.sv
// -----------------------------------------------------------------------------
// loop_sequencer_if
// Request/acknowledge link between the loop sequencer and the external 16-bit
// cellular RAM controller.
//   mem_req    sequencer -> controller  transaction request, held until mem_ack
//   mem_we     sequencer -> controller  1 = write, 0 = read
//   mem_addr   sequencer -> controller  word address
//   mem_wdata  sequencer -> controller  write data
//   mem_ack    controller -> sequencer  one-cycle completion pulse
//   mem_rdata  controller -> sequencer  read data, valid in the mem_ack cycle
// -----------------------------------------------------------------------------
interface loop_sequencer_if #(
  parameter int ADDR_W = 23
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/loop_sequencer.sv
// -----------------------------------------------------------------------------
// loop_sequencer
// Records, loop-plays and overdubs the synthesiser sample stream through the
// external cellular RAM. One memory transaction (or read+write pair when
// overdubbing) is issued per sample tick.
//   clk, rst_n    system clock, asynchronous active-low reset
//   sample_tick   one-cycle strobe per audio sample
//   btn_rec       advance IDLE->RECORD->PLAY<->OVERDUB
//   btn_clr       clear the loop and return to IDLE (wins over btn_rec)
//   sig_in        signed sample from the signal adder
//   mem           memory controller link (master side)
//   sig_out       signed sample to the output stage
//   loop_len      recorded loop length in samples
//   mode          0=IDLE 1=RECORD 2=PLAY 3=OVERDUB
//   overrun       sticky flag: a tick arrived while memory was busy
// -----------------------------------------------------------------------------
module loop_sequencer #(
  parameter int ADDR_W  = 23,
  parameter int MAX_LEN = 8388607
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              btn_rec,
  input  logic              btn_clr,
  input  logic [15:0]       sig_in,
  loop_sequencer_if.master  mem,
  output logic [15:0]       sig_out,
  output logic [ADDR_W-1:0] loop_len,
  output logic [1:0]        mode,
  output logic              overrun
);

  typedef enum logic [1:0] {
    MD_IDLE    = 2'd0,
    MD_RECORD  = 2'd1,
    MD_PLAY    = 2'd2,
    MD_OVERDUB = 2'd3
  } mode_e;

  typedef enum logic [1:0] {M_IDLE, M_RD, M_WR} phase_e;

  localparam logic [ADDR_W-1:0] LEN_MAX = ADDR_W'(MAX_LEN);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  mode_e             mode_q, b_mode, n_mode;
  phase_e            phase;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, len_q;
  logic [ADDR_W-1:0] b_wr, b_rd, b_len, n_wr, n_rd, n_len, rd_next;
  logic [15:0]       s_cap;
  logic              pend_clr, pend_rec;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              ack_fire, done, cmd_window, eff_clr, eff_rec;
  logic signed [16:0] sum17;
  logic [15:0]       sum_sat;

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign loop_len      = len_q;
  assign mode          = mode_q;

  // An ack only counts while a request is outstanding.
  assign ack_fire = req_q && mem.mem_ack;
  // The overdub read ack is not a completion: its write half follows at once.
  assign done     = ack_fire && ((phase == M_WR) || (mode_q != MD_OVERDUB));
  assign rd_next  = (rd_ptr == len_q - ONE) ? '0 : rd_ptr + ONE;

  assign sum17 = $signed({mem.mem_rdata[15], mem.mem_rdata}) + $signed({s_cap[15], s_cap});

  // Commands are taken while memory is idle or on the completing edge; a fresh
  // button in that same cycle supersedes the latched one.
  assign cmd_window = (phase == M_IDLE) || done;
  assign eff_clr    = (btn_clr || btn_rec) ? btn_clr : pend_clr;
  assign eff_rec    = (btn_clr || btn_rec) ? (btn_rec && !btn_clr) : pend_rec;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sum_sat = sum17[15:0];
    if (sum17[16] != sum17[15]) sum_sat = sum17[16] ? 16'h8000 : 16'h7FFF;
  end

  // Next mode/pointer state: completion effects first, then any command on top.
  always_comb begin
    b_mode = mode_q;
    b_wr   = wr_ptr;
    b_rd   = rd_ptr;
    b_len  = len_q;
    if (done) begin
      if (phase == M_WR && mode_q == MD_RECORD) begin
        b_wr = wr_ptr + ONE;
        if (wr_ptr == LEN_MAX - ONE) begin
          b_len  = LEN_MAX;
          b_rd   = '0;
          b_mode = MD_PLAY;
        end
      end else begin
        b_rd = rd_next;
      end
    end

    n_mode = b_mode;
    n_wr   = b_wr;
    n_rd   = b_rd;
    n_len  = b_len;
    if (cmd_window && eff_clr) begin
      n_mode = MD_IDLE;
      n_wr   = '0;
      n_rd   = '0;
      n_len  = '0;
    end else if (cmd_window && eff_rec) begin
      unique case (b_mode)
        MD_IDLE: begin
          n_mode = MD_RECORD;
          n_wr   = '0;
        end
        MD_RECORD: begin
          if (b_wr == '0) begin
            n_mode = MD_IDLE;
          end else begin
            n_mode = MD_PLAY;
            n_len  = b_wr;
            n_rd   = '0;
          end
        end
        MD_PLAY:    n_mode = MD_OVERDUB;
        MD_OVERDUB: n_mode = MD_PLAY;
        default:    n_mode = MD_IDLE;
      endcase
    end
  end

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= M_IDLE;
      mode_q   <= MD_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      len_q    <= '0;
      s_cap    <= '0;
      pend_clr <= 1'b0;
      pend_rec <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sig_out  <= '0;
      overrun  <= 1'b0;
    end else begin
      mode_q <= n_mode;
      wr_ptr <= n_wr;
      rd_ptr <= n_rd;
      len_q  <= n_len;

      if (cmd_window) begin
        pend_clr <= 1'b0;
        pend_rec <= 1'b0;
      end else if (btn_clr || btn_rec) begin
        pend_clr <= btn_clr;
        pend_rec <= btn_rec && !btn_clr;
      end

      if (cmd_window && eff_clr) overrun <= 1'b0;

      unique case (phase)
        M_IDLE: begin
          if (sample_tick) begin
            s_cap <= sig_in;
            unique case (n_mode)
              MD_IDLE: sig_out <= sig_in;
              MD_RECORD: begin
                sig_out <= sig_in;
                phase   <= M_WR;
                req_q   <= 1'b1;
                we_q    <= 1'b1;
                addr_q  <= n_wr;
                wdata_q <= sig_in;
              end
              default: begin
                phase  <= M_RD;
                req_q  <= 1'b1;
                we_q   <= 1'b0;
                addr_q <= n_rd;
              end
            endcase
          end
        end
        M_RD: begin
          if (sample_tick) overrun <= 1'b1;
          if (ack_fire) begin
            req_q <= 1'b0;
            if (mode_q == MD_OVERDUB) begin
              // Write the mixed sample back to the same address next.
              sig_out <= sum_sat;
              phase   <= M_WR;
              we_q    <= 1'b1;
              wdata_q <= sum_sat;
            end else begin
              sig_out <= mem.mem_rdata;
              phase   <= M_IDLE;
            end
          end
        end
        M_WR: begin
          if (sample_tick) overrun <= 1'b1;
          // The overdub write enters with req low for one cycle after the read ack.
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (mem.mem_ack) begin
            req_q <= 1'b0;
            phase <= M_IDLE;
          end
        end
        default: phase <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_loop_sequencer
// Directed scenarios for record/play/overdub/overrun/clear/reset, followed by a
// randomized command+sample sequence compared against a transaction-level model
// of the looper. A small RAM model acks each request 3 cycles after it rises.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_loop_sequencer;
  localparam int ADDR_W  = 4;
  localparam int MAX_LEN = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_tick = 1'b0;
  logic              btn_rec = 1'b0;
  logic              btn_clr = 1'b0;
  logic [15:0]       sig_in = '0;
  logic [15:0]       sig_out;
  logic [ADDR_W-1:0] loop_len;
  logic [1:0]        mode;
  logic              overrun;

  loop_sequencer_if #(.ADDR_W(ADDR_W)) mem ();

  loop_sequencer #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .btn_rec     (btn_rec),
    .btn_clr     (btn_clr),
    .sig_in      (sig_in),
    .mem         (mem),
    .sig_out     (sig_out),
    .loop_len    (loop_len),
    .mode        (mode),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // ---------------- RAM model with transaction log ----------------
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } txn_t;

  logic [15:0] ram [0:(1<<ADDR_W)-1];
  int unsigned lat_cnt;
  txn_t        txq[$];

  initial for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.mem_ack   <= 1'b0;
      mem.mem_rdata <= '0;
      lat_cnt       <= 0;
    end else begin
      mem.mem_ack <= 1'b0;
      if (mem.mem_req && !mem.mem_ack) begin
        if (lat_cnt == 2) begin
          mem.mem_ack <= 1'b1;
          lat_cnt     <= 0;
          if (mem.mem_we) begin
            ram[mem.mem_addr] <= mem.mem_wdata;
            txq.push_back('{we: 1'b1, addr: mem.mem_addr, data: mem.mem_wdata});
          end else begin
            mem.mem_rdata <= ram[mem.mem_addr];
            txq.push_back('{we: 1'b0, addr: mem.mem_addr, data: ram[mem.mem_addr]});
          end
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_txn(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [15:0] data);
    txn_t e;
    check({tag, "_avail"}, 32'(txq.size() != 0), 32'd1);
    if (txq.size() == 0) return;
    e = txq.pop_front();
    check(tag, {11'd0, e.we, e.addr, e.data}, {11'd0, we, addr, data});
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pulse_tick(input logic [15:0] x);
    @(negedge clk);
    sig_in      = x;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic pulse_cmd(input logic clr, input logic rec);
    @(negedge clk);
    btn_clr = clr;
    btn_rec = rec;
    @(negedge clk);
    btn_clr = 1'b0;
    btn_rec = 1'b0;
  endtask

  // One tick followed by enough idle time for any transaction to finish.
  task automatic tick_wait(input logic [15:0] x);
    pulse_tick(x);
    repeat (18) @(negedge clk);
  endtask

  // ---------------- behavioural looper model ----------------
  int          m_mode, m_len, m_wr, m_rd;
  logic [15:0] m_out;
  logic [15:0] ref_mem [0:MAX_LEN-1];

  task automatic model_reset();
    m_mode = 0; m_len = 0; m_wr = 0; m_rd = 0; m_out = '0;
    for (int i = 0; i < MAX_LEN; i++) ref_mem[i] = '0;
  endtask

  task automatic model_cmd(input logic clr, input logic rec);
    if (clr) begin
      m_mode = 0; m_len = 0; m_wr = 0; m_rd = 0;
    end else if (rec) begin
      case (m_mode)
        0: begin m_mode = 1; m_wr = 0; end
        1: if (m_wr == 0) m_mode = 0;
           else begin m_mode = 2; m_len = m_wr; m_rd = 0; end
        2: m_mode = 3;
        default: m_mode = 2;
      endcase
    end
  endtask

  task automatic model_tick(input logic [15:0] x);
    int s;
    case (m_mode)
      0: m_out = x;
      1: begin
        ref_mem[m_wr] = x;
        m_out = x;
        m_wr++;
        if (m_wr == MAX_LEN) begin m_len = MAX_LEN; m_rd = 0; m_mode = 2; end
      end
      2: begin
        m_out = ref_mem[m_rd];
        m_rd  = (m_rd + 1) % m_len;
      end
      default: begin
        s = int'($signed(ref_mem[m_rd])) + int'($signed(x));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        ref_mem[m_rd] = 16'(s);
        m_out = 16'(s);
        m_rd  = (m_rd + 1) % m_len;
      end
    endcase
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500us;
    $display("FAIL watchdog simulation did not finish checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] x;
    int          r;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_mode",     32'(mode),        32'd0);
    check("rst_sig_out",  32'(sig_out),     32'd0);
    check("rst_loop_len", 32'(loop_len),    32'd0);
    check("rst_req",      32'(mem.mem_req), 32'd0);
    check("rst_overrun",  32'(overrun),     32'd0);

    // IDLE passthrough
    pulse_tick(16'h1234);
    check("idle_sig_out", 32'(sig_out),     32'h1234);
    check("idle_req",     32'(mem.mem_req), 32'd0);
    repeat (8) @(negedge clk);
    check("idle_no_txn",  32'(txq.size()),  32'd0);

    // Record 3 samples and stop
    pulse_cmd(1'b0, 1'b1);
    check("rec_mode", 32'(mode), 32'd1);
    tick_wait(16'd10);
    tick_wait(16'd20);
    tick_wait(16'd30);
    for (int i = 0; i < 3; i++) check_txn("rec_wr", 1'b1, ADDR_W'(i), 16'(10 * (i + 1)));
    pulse_cmd(1'b0, 1'b1);
    check("stop_mode",     32'(mode),     32'd2);
    check("stop_loop_len", 32'(loop_len), 32'd3);
    tick_wait(16'h0);
    check("play0_sig_out", 32'(sig_out), 32'd10);
    tick_wait(16'h0);
    check("play1_sig_out", 32'(sig_out), 32'd20);
    tick_wait(16'h0);
    check("play2_sig_out", 32'(sig_out), 32'd30);
    tick_wait(16'h0);
    check("play3_sig_out", 32'(sig_out), 32'd10);
    check_txn("play_rd0", 1'b0, ADDR_W'(0), 16'd10);
    check_txn("play_rd1", 1'b0, ADDR_W'(1), 16'd20);
    check_txn("play_rd2", 1'b0, ADDR_W'(2), 16'd30);
    check_txn("play_rd3", 1'b0, ADDR_W'(0), 16'd10);

    // Record to MAX_LEN: automatic switch to PLAY
    pulse_cmd(1'b1, 1'b0);
    check("clr_mode", 32'(mode), 32'd0);
    check("clr_len",  32'(loop_len), 32'd0);
    pulse_cmd(1'b0, 1'b1);
    for (int i = 0; i < MAX_LEN; i++) tick_wait(16'(100 + i));
    check("full_mode",     32'(mode),     32'd2);
    check("full_loop_len", 32'(loop_len), 32'(MAX_LEN));
    check("full_txn_cnt",  32'(txq.size()), 32'(MAX_LEN));
    txq.delete();
    tick_wait(16'h0);
    check("full_wrap_sig_out", 32'(sig_out), 32'd100);
    check_txn("full_wrap_rd", 1'b0, ADDR_W'(0), 16'd100);

    // Overdub saturation
    pulse_cmd(1'b1, 1'b0);
    pulse_cmd(1'b0, 1'b1);
    tick_wait(16'd32000);
    tick_wait(-16'sd32000);
    pulse_cmd(1'b0, 1'b1);
    pulse_cmd(1'b0, 1'b1);
    check("od_mode", 32'(mode), 32'd3);
    txq.delete();
    tick_wait(16'd1000);
    check("od_pos_sig_out", 32'(sig_out), 32'h7FFF);
    check_txn("od_pos_rd", 1'b0, ADDR_W'(0), 16'd32000);
    check_txn("od_pos_wr", 1'b1, ADDR_W'(0), 16'h7FFF);
    tick_wait(-16'sd1000);
    check("od_neg_sig_out", 32'(sig_out), 32'h8000);
    check_txn("od_neg_rd", 1'b0, ADDR_W'(1), -16'sd32000);
    check_txn("od_neg_wr", 1'b1, ADDR_W'(1), 16'h8000);

    // Overrun: second tick 2 cycles after the first is dropped
    pulse_cmd(1'b0, 1'b1);
    check("back_to_play", 32'(mode), 32'd2);
    pulse_tick(16'h0);
    pulse_tick(16'h5555);
    repeat (16) @(negedge clk);
    check("ovr_flag",    32'(overrun), 32'd1);
    check("ovr_sig_out", 32'(sig_out), 32'h7FFF);
    tick_wait(16'h0);
    check("ovr_no_advance", 32'(sig_out), 32'h8000);

    // Command during a transaction is held until completion
    pulse_tick(16'h0);
    pulse_cmd(1'b0, 1'b1);
    check("pend_held",    32'(mode), 32'd2);
    repeat (15) @(negedge clk);
    check("pend_applied", 32'(mode), 32'd3);
    check("pend_sig_out", 32'(sig_out), 32'h7FFF);
    check("ovr_sticky",   32'(overrun), 32'd1);

    // Clear, then clr+rec together
    pulse_cmd(1'b1, 1'b0);
    check("clr2_overrun", 32'(overrun),  32'd0);
    check("clr2_mode",    32'(mode),     32'd0);
    check("clr2_len",     32'(loop_len), 32'd0);
    pulse_cmd(1'b1, 1'b1);
    check("clr_wins_mode", 32'(mode), 32'd0);

    // Asynchronous reset mid-transaction
    pulse_cmd(1'b0, 1'b1);
    pulse_tick(16'h0777);
    check("busy_req", 32'(mem.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_req",      32'(mem.mem_req), 32'd0);
    check("arst_sig_out",  32'(sig_out),     32'd0);
    check("arst_mode",     32'(mode),        32'd0);
    check("arst_loop_len", 32'(loop_len),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txq.delete();

    // Randomized commands and samples against the looper model
    model_reset();
    for (int it = 0; it < 90; it++) begin
      r = int'($urandom_range(0, 15));
      if (r < 1) begin
        pulse_cmd(1'b1, 1'($urandom_range(0, 1)));
        model_cmd(1'b1, 1'b0);
      end else if (r < 3) begin
        pulse_cmd(1'b0, 1'b1);
        model_cmd(1'b0, 1'b1);
      end
      case ($urandom_range(0, 3))
        0:       x = 1'($urandom_range(0, 1)) ? 16'h7E00 : 16'h8200;
        default: x = 16'($urandom);
      endcase
      tick_wait(x);
      model_tick(x);
      check("rnd_sig_out",  32'(sig_out),     32'(m_out));
      check("rnd_mode",     32'(mode),        32'(m_mode));
      check("rnd_loop_len", 32'(loop_len),    32'(m_len));
      check("rnd_req_idle", 32'(mem.mem_req), 32'd0);
    end
    check("rnd_no_overrun", 32'(overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
- Sequences the external 16-bit cellular RAM controller to record, loop-play and overdub the synthesiser output stream.
- One memory transaction is issued per audio sample tick, derived from the I2S LRCK edge.
- The block sits between the signal adder output and the memory controller and drives the sample that goes to the pmod output stage.
- It arbitrates between the read and write phases and owns the record/playback/overdub mode state machine.

Parameters:
ADDR_W, 23, memory word address width (8M x 16 RAM).
MAX_LEN, 8388607, maximum loop length in samples; must be <= 2^ADDR_W-1.

Ports:
clk  input  1  100 MHz system clock
rst_n  input  1  asynchronous active-low reset
sample_tick  input  1  one-cycle strobe per audio sample
btn_rec  input  1  debounced one-cycle command pulse: record/play/overdub advance
btn_clr  input  1  one-cycle command pulse: clear loop, return to IDLE
sig_in  input  16  signed two's-complement sample from signal adder
mem_ack  input  1  one-cycle completion pulse from memory controller
mem_rdata  input  16  read data, valid in the mem_ack cycle
mem_req  output  1  transaction request, held until mem_ack
mem_we  output  1  1=write, 0=read; stable while mem_req high
mem_addr  output  ADDR_W  word address; stable while mem_req high
mem_wdata  output  16  write data; stable while mem_req high
sig_out  output  16  signed sample to output stage
loop_len  output  ADDR_W  recorded loop length in samples
mode  output  2  0=IDLE 1=RECORD 2=PLAY 3=OVERDUB
overrun  output  1  sticky: sample tick dropped

Behaviour:
- Reset (async, rst_n=0): all outputs 0, mode=IDLE, memory phase M_IDLE, pointers 0, pending command cleared.
- Memory phases:
  - M_IDLE, M_RD, M_WR.
  - mem_req rises on the edge after the trigger and falls on the edge after the mem_ack cycle.
  - mem_ack while mem_req=0 is ignored.
- Tick in M_IDLE: sig_in is captured to s_cap, then by mode:
  - IDLE: sig_out<=sig_in on the next edge; no memory access.
  - RECORD: M_WR at wr_ptr, wdata=s_cap; sig_out<=s_cap on the next edge. On ack, wr_ptr++. If wr_ptr reaches MAX_LEN: loop_len<=MAX_LEN, rd_ptr<=0, mode->PLAY.
  - PLAY: M_RD at rd_ptr. On ack, sig_out<=mem_rdata and rd_ptr advances.
  - OVERDUB: M_RD at rd_ptr. On ack, sum=sat16(mem_rdata+s_cap); sig_out<=sum; then M_WR at the same address with sum. On that write's ack, rd_ptr advances.
- sat16: 17-bit signed add, clamped to 32767 / -32768.
- rd_ptr advance: if rd_ptr==loop_len-1 then 0, else +1.
- Tick while phase != M_IDLE: the tick is dropped, overrun<=1, and no state or pointer change occurs.
- Commands are accepted only in M_IDLE. A command arriving mid-transaction is latched (one-deep; a later command overwrites it) and applied on the edge the transaction completes.
- btn_clr and btn_rec in the same cycle: clr wins.
- btn_rec transitions:
  - IDLE->RECORD, wr_ptr<=0.
  - RECORD->PLAY with loop_len<=wr_ptr and rd_ptr<=0. If wr_ptr==0, go to IDLE instead.
  - PLAY->OVERDUB.
  - OVERDUB->PLAY.
- btn_clr: mode->IDLE, loop_len<=0, pointers<=0, overrun<=0.
- A tick and a command in the same M_IDLE cycle: the command applies first, and the tick is serviced in the new mode.
- An in-flight transaction is never aborted except by reset. Reset mid-transaction drops mem_req immediately.

Test Plan:
- Setup: MAX_LEN=8; memory model acks 3 cycles after req; ticks every 20 cycles.
- Reset with rst_n=0 mid-transaction -> mem_req=0, sig_out=0, mode=0, loop_len=0 asynchronously.
- IDLE, sig_in=16'h1234, tick -> sig_out=16'h1234 next cycle, mem_req stays 0.
- btn_rec, then 3 ticks with sig_in=10,20,30, then btn_rec -> writes to addr 0,1,2 with wdata 10,20,30; loop_len=3, mode=2. Next 4 ticks read addr 0,1,2,0 with sig_out=10,20,30,10.
- Record 8 ticks without a stop -> after the 8th ack, mode=2 and loop_len=8 automatically. Next read is at addr 0.
- OVERDUB with stored value 32000 and sig_in=1000 -> read then write at the same address, wdata=32767, sig_out=32767. With stored -32000 and sig_in=-1000 -> -32768.
- Tick issued 2 cycles after a previous tick (memory busy) -> tick dropped, overrun=1. btn_clr -> overrun=0, mode=0, loop_len=0. btn_clr and btn_rec in the same cycle -> mode=0.
